// File: rtl/posit_encoder_pipe_pkg.sv
// Shared types, widths and helpers for the posit encoder lane tail.
// Module-width values come in as arguments because the package cannot see module parameters.
package posit_encoder_pipe_pkg;

   localparam int unsigned K_SIZE       = 8;
   localparam int unsigned REG_LEN_SIZE = K_SIZE + 1;
   localparam int unsigned MAX_N        = 64;
   localparam int unsigned MAX_ES       = 4;
   localparam int unsigned MAX_FRAC_W   = 64;

   typedef struct packed {
      logic                         sign;
      logic signed [K_SIZE-1:0]     k;
      logic [MAX_ES-1:0]            exp;
      logic [MAX_FRAC_W-1:0]        frac;
      logic                         sticky;
   } posit_unpacked_t;

   function automatic logic [MAX_N-1:0] maxpos(input int unsigned n);
      return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
   endfunction

   function automatic logic [MAX_N-1:0] minpos();
      return MAX_N'(1);
   endfunction

   function automatic logic [MAX_N-1:0] nar(input int unsigned n);
      return MAX_N'(1) << (n - 1);
   endfunction

   function automatic logic [MAX_N-1:0] c2(input logic [MAX_N-1:0] x);
      return ~x + MAX_N'(1);
   endfunction

   // Returns the increment decision for round-to-nearest-even.
   function automatic logic round_nearest_even(input logic lsb, input logic g, input logic s);
      return g & (lsb | s);
   endfunction

endpackage

// File: rtl/posit_encoder_pipe_if.sv
// Input and output beat signals of the posit encoder, with both handshakes.
interface posit_encoder_pipe_if
   import posit_encoder_pipe_pkg::*;
#(
   parameter int unsigned N      = 16,
   parameter int unsigned ES     = 1,
   parameter int unsigned FRAC_W = 16
);
   localparam int unsigned EW = (ES > 0) ? ES : 1;

   logic                     valid_i;
   logic                     ready_o;
   logic                     is_zero_i;
   logic                     is_nar_i;
   logic                     sign_i;
   logic signed [K_SIZE-1:0] k_i;
   logic [EW-1:0]            exp_i;
   logic [FRAC_W-1:0]        frac_i;
   logic                     sticky_i;
   logic                     valid_o;
   logic                     ready_i;
   logic [N-1:0]             posit_o;
   logic                     inexact_o;

   modport slave (
      input  valid_i, is_zero_i, is_nar_i, sign_i, k_i, exp_i, frac_i, sticky_i, ready_i,
      output ready_o, valid_o, posit_o, inexact_o
   );

   modport master (
      output valid_i, is_zero_i, is_nar_i, sign_i, k_i, exp_i, frac_i, sticky_i, ready_i,
      input  ready_o, valid_o, posit_o, inexact_o
   );
endinterface

// File: rtl/posit_encoder_pipe_round.sv
// Round-to-nearest-even on an unsigned posit magnitude (sign bit excluded).
// Clamps at maxpos so the magnitude never carries into the NaR pattern, and never yields zero.
module posit_round_rne
   import posit_encoder_pipe_pkg::*;
#(
   parameter int unsigned MAG_W = 15
) (
   input  logic [MAG_W-1:0] mag_i,
   input  logic             g_i,
   input  logic             s_i,
   output logic [MAG_W-1:0] mag_o,
   output logic             inexact_o
);
   logic             inc;
   logic [MAG_W:0]   sum;

   always_comb begin
      inc       = round_nearest_even(mag_i[0], g_i, s_i);
      sum       = {1'b0, mag_i} + {{MAG_W{1'b0}}, inc};
      mag_o     = sum[MAG_W-1:0];
      if (sum[MAG_W]) begin
         mag_o = '1;
      end else if (mag_o == '0) begin
         mag_o = {{(MAG_W-1){1'b0}}, 1'b1};
      end
      inexact_o = g_i | s_i;
   end
endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage rounding posit encoder: S1 assembles regime|exp|frac and extracts guard/sticky,
// S2 rounds, negates and applies specials. Valid/ready chain with no skid buffer.
module posit_encoder_pipe
   import posit_encoder_pipe_pkg::*;
#(
   parameter int unsigned N      = 16,
   parameter int unsigned ES     = 1,
   parameter int unsigned FRAC_W = 16
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   posit_encoder_pipe_if.slave bus
);
   localparam int unsigned W  = 2 * N + FRAC_W;
   localparam int unsigned M  = N - 1;
   localparam int unsigned EW = (ES > 0) ? ES : 1;

   localparam logic [MAX_N-1:0] MAXPOS_W = maxpos(N);
   localparam logic [MAX_N-1:0] MINPOS_W = minpos();
   localparam logic [MAX_N-1:0] NAR_W    = nar(N);

   localparam logic signed [REG_LEN_SIZE-1:0] K_MAX = $signed(REG_LEN_SIZE'(N - 2));
   localparam logic signed [REG_LEN_SIZE-1:0] K_MIN = -$signed(REG_LEN_SIZE'(N - 1));

   logic s1_v_q, s2_v_q, s1_load, s2_load;

   // ---------------- S1 assemble ----------------
   logic signed [REG_LEN_SIZE-1:0] k_ext;
   logic                           k_neg;
   logic [REG_LEN_SIZE-1:0]        shamt;
   logic [W-1:0]                   body, field;
   logic                           tail_zero, sat_max, sat_min, sat_exact;
   logic [M-1:0]                   s1_mag_d;
   logic                           s1_g_d, s1_s_d;

   always_comb begin
      k_ext = {bus.k_i[K_SIZE-1], bus.k_i};
      k_neg = k_ext[REG_LEN_SIZE-1];
      // Shift = reg_len - 1; the terminating regime bit comes from the top bit of body.
      if (k_neg) shamt = $unsigned(-k_ext);
      else       shamt = $unsigned(k_ext) + REG_LEN_SIZE'(1);

      if (ES == 0) body = {k_neg, bus.frac_i, {(W - 1 - FRAC_W){1'b0}}};
      else         body = {k_neg, bus.exp_i, bus.frac_i, {(W - 1 - EW - FRAC_W){1'b0}}};

      field = body >> shamt;
      if (!k_neg) field = field | ~({W{1'b1}} >> shamt);

      tail_zero = ((ES == 0) || (bus.exp_i == '0)) && (bus.frac_i == '0) && !bus.sticky_i;
      sat_max   = k_ext >= K_MAX;
      sat_min   = k_ext <= K_MIN;
      sat_exact = (k_ext == K_MAX) && tail_zero;

      s1_mag_d = field[W-1 -: M];
      s1_g_d   = field[W-1-M];
      s1_s_d   = (|field[W-2-M:0]) | bus.sticky_i;
      // Saturation is folded in with g=0 so S2 never increments it; s carries inexactness.
      if (sat_max) begin
         s1_mag_d = MAXPOS_W[M-1:0];
         s1_g_d   = 1'b0;
         s1_s_d   = !sat_exact;
      end else if (sat_min) begin
         s1_mag_d = MINPOS_W[M-1:0];
         s1_g_d   = 1'b0;
         s1_s_d   = 1'b1;
      end
   end

   logic [M-1:0] s1_mag_q;
   logic         s1_g_q, s1_s_q, s1_sign_q, s1_nar_q, s1_zero_q;

   always_ff @(posedge clk_i) begin
      if (s1_load && bus.valid_i) begin
         s1_mag_q  <= s1_mag_d;
         s1_g_q    <= s1_g_d;
         s1_s_q    <= s1_s_d;
         s1_sign_q <= bus.sign_i;
         s1_nar_q  <= bus.is_nar_i;
         s1_zero_q <= bus.is_zero_i;
      end
   end

   // ---------------- S2 round / negate ----------------
   logic [M-1:0] rnd_mag;
   logic         rnd_inexact;
   logic [N-1:0] posit_d, posit_q;
   logic         inexact_d, inexact_q;

   posit_round_rne #(
      .MAG_W (M)
   ) u_round (
      .mag_i     (s1_mag_q),
      .g_i       (s1_g_q),
      .s_i       (s1_s_q),
      .mag_o     (rnd_mag),
      .inexact_o (rnd_inexact)
   );

   always_comb begin
      posit_d   = s1_sign_q ? (~{1'b0, rnd_mag} + N'(1)) : {1'b0, rnd_mag};
      inexact_d = rnd_inexact;
      if (s1_nar_q) begin
         posit_d   = NAR_W[N-1:0];
         inexact_d = 1'b0;
      end else if (s1_zero_q) begin
         posit_d   = '0;
         inexact_d = 1'b0;
      end
   end

   // ---------------- handshake ----------------
   assign s2_load = !s2_v_q || bus.ready_i;
   assign s1_load = !s1_v_q || s2_load;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         posit_q   <= '0;
         inexact_q <= 1'b0;
      end else begin
         if (s1_load) s1_v_q <= bus.valid_i;
         if (s2_load) s2_v_q <= s1_v_q;
         if (s2_load && s1_v_q) begin
            posit_q   <= posit_d;
            inexact_q <= inexact_d;
         end
      end
   end

   assign bus.ready_o   = s1_load;
   assign bus.valid_o   = s2_v_q;
   assign bus.posit_o   = posit_q;
   assign bus.inexact_o = inexact_q;
endmodule
